hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline scheduler for the 5-stage CPU: per-cycle stall/flush control for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Detects load-use and decode-branch hazards, squashes the fetch slot on mispredict, runs HLT drain FSM.
//  Sits beside Decode; consumes ID-stage reg IDs and downstream WB/MEM control fields.
// PARAMETERS
//  CNT_W  16  width of saturating stall/flush performance counters
// PORTS
//  clk               in   1      system clock; single clock domain
//  rst_n             in   1      synchronous, active-low reset
//  ID_SrcReg1        in   4      decode source reg 1 (Rs for BR)
//  ID_SrcReg2        in   4      decode source reg 2
//  ID_src1_used      in   1      SrcReg1 read by decode instr
//  ID_src2_used      in   1      SrcReg2 read by decode instr
//  ID_is_branch      in   1      decode instr is B or BR
//  ID_is_BR          in   1      decode branch is BR (needs Rs)
//  ID_update_PC      in   1      decode resolved mispredict
//  ID_HLT            in   1      decode instr is HLT
//  ID_EX_reg_rd      in   4      EX-stage destination
//  ID_EX_RegWrite    in   1      EX-stage writes RF
//  ID_EX_MemRead     in   1      EX-stage is LW
//  ID_EX_flag_wr     in   1      EX-stage Z_en|NV_en
//  EX_MEM_reg_rd     in   4      MEM-stage destination
//  EX_MEM_MemRead    in   1      MEM-stage is LW
//  mem_stall         in   1      memory not ready; freeze pipe
//  MEM_WB_HLT        in   1      HLT reached WB
//  PC_stall          out  1      hold PC
//  IF_ID_stall       out  1      hold IF/ID
//  IF_ID_flush       out  1      load NOP into IF/ID
//  ID_EX_flush       out  1      load bubble into ID/EX
//  pipe_freeze       out  1      hold ID/EX, EX/MEM, MEM/WB
//  halted            out  1      processor halted (sticky)
//  stall_cnt         out  CNT_W  hazard stall cycles, saturating
//  flush_cnt         out  CNT_W  mispredict flushes, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=RUN, halted=0, counters=0. While rst_n=0: PC_stall=IF_ID_stall=pipe_freeze=0, IF_ID_flush=ID_EX_flush=1.
//  Hazard terms are combinational, same cycle; R0 never creates a hazard.
//   lu  = ID_EX_MemRead & rd==used src & rd!=0
//   bf  = ID_is_branch & !ID_is_BR & ID_EX_flag_wr
//   br1 = ID_is_BR & ID_EX_RegWrite & ID_EX_reg_rd==ID_SrcReg1 & rd!=0
//   br2 = ID_is_BR & EX_MEM_MemRead & EX_MEM_reg_rd==ID_SrcReg1 & rd!=0
//   haz = lu|bf|br1|br2
//  Priority, highest first:
//   1. HALTED: PC_stall=IF_ID_stall=pipe_freeze=1; no flushes.
//   2. mem_stall: PC_stall=IF_ID_stall=pipe_freeze=1; flushes=0; ID_update_PC/ID_HLT ignored this cycle.
//   3. haz: PC_stall=IF_ID_stall=1, ID_EX_flush=1; mispredict ignored (branch re-evaluates next cycle).
//   4. ID_update_PC: IF_ID_flush=1 (PC loads actual target; Decode drives it).
//   5. Otherwise all 0.
//  Load feeding BR: 2 stall cycles (br1 then br2).
//  FSM states RUN, DRAIN, HALTED:
//   RUN->DRAIN when ID_HLT & !haz & !mem_stall; in DRAIN, PC_stall=1, IF_ID_flush=1, pipe advances.
//   DRAIN->HALTED when MEM_WB_HLT & !mem_stall; halted=1 from the next cycle.
//   HALTED is left only via reset; rst_n=0 in any state returns to RUN next edge.
//  stall_cnt +1 per cycle in RUN with haz & !mem_stall; flush_cnt +1 per cycle with case-4 flush. Both hold at 2^CNT_W-1.
// TESTING
//  LW R3 in EX, ID uses R3 as src2 -> 1 cycle PC_stall/IF_ID_stall/ID_EX_flush, then clear; stall_cnt=1.
//  LW R5 in EX, BR R5 in ID -> stalls 2 cycles (br1, br2), stall_cnt=2; same with rd=R0 -> no stall.
//  ID_update_PC=1 with no hazard -> IF_ID_flush=1 for 1 cycle, flush_cnt=1; with mem_stall=1 same cycle -> freeze only, flush_cnt=0.
//  ID_HLT=1 -> DRAIN: PC_stall=1 and IF_ID_flush=1 until MEM_WB_HLT pulse; halted=1 the cycle after, stays 1 for 10 cycles.
//  rst_n=0 for 1 cycle mid-DRAIN -> next cycle RUN, halted=0, counters=0, PC_stall=0.
//  CNT_W=4, 20 consecutive lu cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the 5-stage pipeline with HLT drain FSM
//   Detects load-use and decode-branch hazards, squashes the fetch slot on a
//   decode-resolved mispredict, drains the pipe on HLT and then halts.
//   Inputs : clk, rst_n (sync, active low), ID-stage source regs/usage/branch
//            info, ID/EX and EX/MEM destination/control fields, mem_stall,
//            MEM_WB_HLT.
//   Outputs: PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, pipe_freeze,
//            halted (sticky), stall_cnt / flush_cnt (saturating, CNT_W bits).
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ID_SrcReg1,
  input  logic [3:0]       ID_SrcReg2,
  input  logic             ID_src1_used,
  input  logic             ID_src2_used,
  input  logic             ID_is_branch,
  input  logic             ID_is_BR,
  input  logic             ID_update_PC,
  input  logic             ID_HLT,
  input  logic [3:0]       ID_EX_reg_rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_flag_wr,
  input  logic [3:0]       EX_MEM_reg_rd,
  input  logic             EX_MEM_MemRead,
  input  logic             mem_stall,
  input  logic             MEM_WB_HLT,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t r_state, w_next;
  logic w_lu, w_bf, w_br1, w_br2, w_haz, w_flush_inc, w_stall_inc;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  // R0 is hardwired zero, so a write to it never creates a dependency
  assign w_lu  = ID_EX_MemRead && ID_EX_reg_rd != 4'd0 &&
                 ((ID_src1_used && ID_EX_reg_rd == ID_SrcReg1) ||
                  (ID_src2_used && ID_EX_reg_rd == ID_SrcReg2));
  // conditional B reads flags that the EX-stage instruction is still producing
  assign w_bf  = ID_is_branch && !ID_is_BR && ID_EX_flag_wr;
  // BR reads Rs in decode, so any producer in EX, or a load in MEM, must finish first
  assign w_br1 = ID_is_BR && ID_EX_RegWrite && ID_EX_reg_rd != 4'd0 &&
                 ID_EX_reg_rd == ID_SrcReg1;
  assign w_br2 = ID_is_BR && EX_MEM_MemRead && EX_MEM_reg_rd != 4'd0 &&
                 EX_MEM_reg_rd == ID_SrcReg1;
  assign w_haz = w_lu || w_bf || w_br1 || w_br2;
  assign w_stall_inc = rst_n && r_state == RUN && w_haz && !mem_stall;
  always_comb begin
    w_next      = r_state;
    PC_stall    = 1'b0;
    IF_ID_stall = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    pipe_freeze = 1'b0;
    w_flush_inc = 1'b0;
    if (!rst_n) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      w_next      = RUN;
    end else if (r_state == HALTED || mem_stall) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      pipe_freeze = 1'b1;
    end else if (r_state == DRAIN) begin
      // fetch is stopped and NOPs follow the HLT down the pipe until it retires
      PC_stall    = 1'b1;
      IF_ID_flush = 1'b1;
      w_next      = MEM_WB_HLT ? HALTED : DRAIN;
    end else if (w_haz) begin
      // a mispredict seen now is dropped; the branch resolves again next cycle
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      IF_ID_flush = ID_update_PC;
      w_flush_inc = ID_update_PC;
      w_next      = ID_HLT ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign halted    = r_state == HALTED;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and directed sequence checks of hazard_ctrl
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst_n;
  logic [3:0] s1, s2, exrd, memrd;
  logic u1, u2, isb, isbr, upd, hlt, exrw, exmr, exfw, memmr, mst, wbhlt;
  logic pc_stall, ifid_stall, ifid_flush, idex_flush, freeze, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_SrcReg1(s1), .ID_SrcReg2(s2), .ID_src1_used(u1), .ID_src2_used(u2),
    .ID_is_branch(isb), .ID_is_BR(isbr), .ID_update_PC(upd), .ID_HLT(hlt),
    .ID_EX_reg_rd(exrd), .ID_EX_RegWrite(exrw), .ID_EX_MemRead(exmr), .ID_EX_flag_wr(exfw),
    .EX_MEM_reg_rd(memrd), .EX_MEM_MemRead(memmr), .mem_stall(mst), .MEM_WB_HLT(wbhlt),
    .PC_stall(pc_stall), .IF_ID_stall(ifid_stall), .IF_ID_flush(ifid_flush),
    .ID_EX_flush(idex_flush), .pipe_freeze(freeze), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  typedef struct {
    string name;
    logic [3:0] s1, s2, exrd, memrd;
    logic u1, u2, isb, isbr, upd, exrw, exmr, exfw, memmr, mst;
    logic [4:0] eo;
    int sc, fc;
  } vec_t;
  function automatic vec_t mk(string n, logic [3:0] a, logic ua, logic [3:0] b, logic ub,
                              logic ib, logic ibr, logic up, logic [3:0] erd, logic erw,
                              logic emr, logic efw, logic [3:0] mrd, logic mmr, logic ms,
                              logic [4:0] eo, int sc, int fc);
    vec_t v;
    v.name = n; v.s1 = a; v.u1 = ua; v.s2 = b; v.u2 = ub; v.isb = ib; v.isbr = ibr;
    v.upd = up; v.exrd = erd; v.exrw = erw; v.exmr = emr; v.exfw = efw; v.memrd = mrd;
    v.memmr = mmr; v.mst = ms; v.eo = eo; v.sc = sc; v.fc = fc;
    return v;
  endfunction
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic clr();
    s1 = 0; s2 = 0; exrd = 0; memrd = 0; u1 = 0; u2 = 0; isb = 0; isbr = 0; upd = 0;
    hlt = 0; exrw = 0; exmr = 0; exfw = 0; memmr = 0; mst = 0; wbhlt = 0;
  endtask
  // outputs packed as {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, pipe_freeze}
  task automatic cyc(string n, logic [4:0] eo, logic eh, int sc, int fc);
    @(negedge clk);
    chk({n, ".ctl"}, int'({pc_stall, ifid_stall, ifid_flush, idex_flush, freeze}), int'(eo));
    chk({n, ".halted"}, int'(halted), int'(eh));
    chk({n, ".stall_cnt"}, int'(stall_cnt), sc);
    chk({n, ".flush_cnt"}, int'(flush_cnt), fc);
    @(posedge clk); #1;
  endtask
  task automatic set_lu();
    s2 = 4'd3; u2 = 1; exrd = 4'd3; exrw = 1; exmr = 1;
  endtask
  vec_t tbl[$];
  initial begin
    int m;
    rst_n = 0; clr();
    @(posedge clk); #1;
    cyc("reset", 5'b00110, 0, 0, 0);
    rst_n = 1;
    tbl.push_back(mk("idle",      0,0, 0,0, 0,0,0, 0,0,0,0, 0,0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk("lu_src2",   0,0, 3,1, 0,0,0, 3,1,1,0, 0,0, 0, 5'b11010, 0, 0));
    tbl.push_back(mk("lu_clear",  0,0, 0,0, 0,0,0, 0,0,0,0, 0,0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk("lu_unused", 0,0, 3,0, 0,0,0, 3,1,1,0, 0,0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk("lu_r0",     0,0, 0,1, 0,0,0, 0,1,1,0, 0,0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk("lu_src1",   7,1, 0,0, 0,0,0, 7,1,1,0, 0,0, 0, 5'b11010, 1, 0));
    tbl.push_back(mk("br1",       5,1, 0,0, 1,1,0, 5,1,1,0, 0,0, 0, 5'b11010, 2, 0));
    tbl.push_back(mk("br2",       5,1, 0,0, 1,1,0, 0,0,0,0, 5,1, 0, 5'b11010, 3, 0));
    tbl.push_back(mk("br_free",   5,1, 0,0, 1,1,0, 0,0,0,0, 0,0, 0, 5'b00000, 4, 0));
    tbl.push_back(mk("br_r0",     0,1, 0,0, 1,1,0, 0,1,1,0, 0,1, 0, 5'b00000, 4, 0));
    tbl.push_back(mk("bf",        0,0, 0,0, 1,0,0, 0,0,0,1, 0,0, 0, 5'b11010, 4, 0));
    tbl.push_back(mk("br_flagwr", 2,1, 0,0, 1,1,0, 0,0,0,1, 0,0, 0, 5'b00000, 5, 0));
    tbl.push_back(mk("mispred",   0,0, 0,0, 0,0,1, 0,0,0,0, 0,0, 0, 5'b00100, 5, 0));
    tbl.push_back(mk("mp_after",  0,0, 0,0, 0,0,0, 0,0,0,0, 0,0, 0, 5'b00000, 5, 1));
    tbl.push_back(mk("mp_memstl", 0,0, 0,0, 0,0,1, 0,0,0,0, 0,0, 1, 5'b11001, 5, 1));
    tbl.push_back(mk("lu_memstl", 0,0, 3,1, 0,0,0, 3,1,1,0, 0,0, 1, 5'b11001, 5, 1));
    tbl.push_back(mk("haz_mp",    0,0, 3,1, 0,0,1, 3,1,1,0, 0,0, 0, 5'b11010, 5, 1));
    tbl.push_back(mk("end_tbl",   0,0, 0,0, 0,0,0, 0,0,0,0, 0,0, 0, 5'b00000, 6, 1));
    foreach (tbl[i]) begin
      s1 = tbl[i].s1; u1 = tbl[i].u1; s2 = tbl[i].s2; u2 = tbl[i].u2;
      isb = tbl[i].isb; isbr = tbl[i].isbr; upd = tbl[i].upd;
      exrd = tbl[i].exrd; exrw = tbl[i].exrw; exmr = tbl[i].exmr; exfw = tbl[i].exfw;
      memrd = tbl[i].memrd; memmr = tbl[i].memmr; mst = tbl[i].mst;
      cyc(tbl[i].name, tbl[i].eo, 0, tbl[i].sc, tbl[i].fc);
    end
    clr(); hlt = 1;
    cyc("hlt_run", 5'b00000, 0, 6, 1);
    hlt = 0;
    cyc("drain0", 5'b10100, 0, 6, 1);
    mst = 1;
    cyc("drain_mst", 5'b11001, 0, 6, 1);
    wbhlt = 1;
    cyc("drain_wb_mst", 5'b11001, 0, 6, 1);
    mst = 0; wbhlt = 0;
    cyc("drain1", 5'b10100, 0, 6, 1);
    wbhlt = 1;
    cyc("drain_wb", 5'b10100, 0, 6, 1);
    wbhlt = 0;
    for (int i = 0; i < 10; i++) begin
      upd = (i == 3);
      cyc($sformatf("halted%0d", i), 5'b11001, 1, 6, 1);
    end
    upd = 0; rst_n = 0;
    cyc("rst_halted", 5'b00110, 1, 6, 1);
    rst_n = 1;
    cyc("post_rst", 5'b00000, 0, 0, 0);
    set_lu();
    cyc("lu_again", 5'b11010, 0, 0, 0);
    clr(); hlt = 1;
    cyc("hlt2", 5'b00000, 0, 1, 0);
    hlt = 0;
    cyc("drain2", 5'b10100, 0, 1, 0);
    rst_n = 0;
    cyc("rst_drain", 5'b00110, 0, 1, 0);
    rst_n = 1;
    cyc("run_after", 5'b00000, 0, 0, 0);
    set_lu();
    m = 0;
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat%0d", i), 5'b11010, 0, m, 0);
      m = (m < 15) ? m + 1 : 15;
    end
    clr();
    cyc("sat_hold", 5'b00000, 0, 15, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
